// File: rtl/bcast_mac_4lane_pkg.sv
// Shared definitions for the four-lane broadcast MAC column.
// Latency: n/a (types, constants and a lane-slice helper only).
// Backpressure: n/a.
package bcast_mac_4lane_pkg;

   // FSM state encoding for the column controller.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   localparam int LANE_W = 16;          // one signed operand lane
   localparam int BUS_W  = 64;          // broadcast bus: four lanes
   localparam int PROD_W = 2 * LANE_W;  // full-precision signed product

   // Extracts lane k from a 64-bit broadcast or weight word.
   function automatic logic [LANE_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                    input int k);
      return bus[k*LANE_W +: LANE_W];
   endfunction

endpackage

// File: rtl/bcast_mac_lane.sv
// One PE: signed 16x16 multiply feeding a wrapping ACC_W-bit accumulator.
// Latency: acc updates at the edge after en; acc_nxt is the combinational next value.
// Backpressure: none; en gates the update, clr has priority and zeroes the sum.
// Ports: clk, rst (sync, active-low), clr, en, data/weight (signed lanes),
//        acc_nxt (value acc will take at the coming edge).
module bcast_mac_lane
   import bcast_mac_4lane_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [LANE_W-1:0] data,
   input  logic [LANE_W-1:0] weight,
   output logic [ACC_W-1:0]  acc_nxt
);

   logic [ACC_W-1:0]         acc;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;

   assign prod     = $signed(data) * $signed(weight);
   // Size cast of a signed value sign-extends to the accumulator width.
   assign prod_ext = ACC_W'(prod);

   always_comb begin
      acc_nxt = acc;
      if (clr) begin
         acc_nxt = '0;
      end else if (en) begin
         // Plain modular add: overflow wraps, no saturation.
         acc_nxt = acc + prod_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/bcast_mac_4lane.sv
// Four-PE column behind one broadcast fanout leaf: per-lane multiply by a
// stationary weight, accumulate over acc_len valid beats, present the sums once.
// Latency: last valid beat in cycle T -> result_v high in cycle T+1.
// Backpressure: none; beats arriving outside ACCUM are discarded and flagged on beat_drop.
// Ports: clk, rst (sync, active-low), start/acc_len (run control),
//        weight_load/weight_data (stationary weights, IDLE only),
//        brdcast_data_v/brdcast_data (beat input), busy, result_v, result_data, beat_drop.
module bcast_mac_4lane
   import bcast_mac_4lane_pkg::*;
#(
   parameter int LANES = 4,
   parameter int ACC_W = 40,
   parameter int LEN_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LEN_W-1:0]       acc_len,
   input  logic                   weight_load,
   input  logic [BUS_W-1:0]       weight_data,
   input  logic                   brdcast_data_v,
   input  logic [BUS_W-1:0]       brdcast_data,
   output logic                   busy,
   output logic                   result_v,
   output logic [LANES*ACC_W-1:0] result_data,
   output logic                   beat_drop
);

   state_t                 state;
   logic [BUS_W-1:0]       weight_q;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       beat_cnt;
   logic [LANES*ACC_W-1:0] acc_nxt_all;
   logic                   start_ok;
   logic                   beat_en;
   logic                   last_beat;

   // A zero-length start is not a run; it is simply ignored.
   assign start_ok  = (state == ST_IDLE) && start && (acc_len != '0);
   assign beat_en   = (state == ST_ACCUM) && brdcast_data_v;
   assign last_beat = beat_en && (beat_cnt == len_q - LEN_W'(1));

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bcast_mac_lane #(
         .ACC_W (ACC_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .clr     (start_ok),
         .en      (beat_en),
         .data    (lane_slice(brdcast_data, k)),
         .weight  (lane_slice(weight_q, k)),
         .acc_nxt (acc_nxt_all[k*ACC_W +: ACC_W])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         weight_q    <= '0;
         len_q       <= '0;
         beat_cnt    <= '0;
         result_data <= '0;
         result_v    <= 1'b0;
         busy        <= 1'b0;
         beat_drop   <= 1'b0;
      end else begin
         result_v  <= 1'b0;
         beat_drop <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               // Any beat here is discarded, including one alongside an accepted start.
               beat_drop <= brdcast_data_v;
               // Weight write and start may coincide; the run then sees the new weights
               // because the first beat cannot arrive before the next cycle.
               if (weight_load) begin
                  weight_q <= weight_data;
               end
               if (start_ok) begin
                  state       <= ST_ACCUM;
                  busy        <= 1'b1;
                  len_q       <= acc_len;
                  beat_cnt    <= '0;
                  result_data <= '0;
               end
            end
            ST_ACCUM: begin
               if (beat_en) begin
                  beat_cnt <= beat_cnt + LEN_W'(1);
                  if (last_beat) begin
                     // Capture the sums including this final beat so they are
                     // presented registered during OUT.
                     state       <= ST_OUT;
                     result_v    <= 1'b1;
                     result_data <= acc_nxt_all;
                  end
               end
            end
            ST_OUT: begin
               beat_drop <= brdcast_data_v;
               state     <= ST_IDLE;
               busy      <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcast_mac_4lane.sv
// Directed + randomized bench for bcast_mac_4lane against a sum-of-products model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcast_mac_4lane;

   localparam int ACC_W = 40;
   localparam int RES_W = 4 * ACC_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       acc_len = '0;
   logic             weight_load = 1'b0;
   logic [63:0]      weight_data = '0;
   logic             brdcast_data_v = 1'b0;
   logic [63:0]      brdcast_data = '0;
   logic             busy;
   logic             result_v;
   logic [RES_W-1:0] result_data;
   logic             beat_drop;

   int               vectors = 0;
   int               miscompares = 0;

   // Reference state: current weights and the beats of the run being checked.
   logic [63:0]      w_model = '0;
   logic [63:0]      beats_q[$];
   logic [RES_W-1:0] exp_res;

   always #5 clk = ~clk;

   bcast_mac_4lane #(
      .LANES (4),
      .ACC_W (ACC_W),
      .LEN_W (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .acc_len        (acc_len),
      .weight_load    (weight_load),
      .weight_data    (weight_data),
      .brdcast_data_v (brdcast_data_v),
      .brdcast_data   (brdcast_data),
      .busy           (busy),
      .result_v       (result_v),
      .result_data    (result_data),
      .beat_drop      (beat_drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Per lane: sum over the run's beats of data_k * w_k, reduced modulo 2^ACC_W.
   function automatic logic [RES_W-1:0] model_sum();
      logic [RES_W-1:0] r;
      longint           s;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         s = 0;
         foreach (beats_q[b]) begin
            s += longint'($signed(beats_q[b][16*k +: 16])) * longint'($signed(w_model[16*k +: 16]));
         end
         r[ACC_W*k +: ACC_W] = s[ACC_W-1:0];
      end
      return r;
   endfunction

   task automatic load_w(input logic [63:0] w);
      weight_load = 1'b1;
      weight_data = w;
      tick();
      weight_load = 1'b0;
      weight_data = {$urandom, $urandom};
      w_model     = w;
   endtask

   task automatic fill_random(input int n);
      beats_q.delete();
      repeat (n) beats_q.push_back({$urandom, $urandom});
   endtask

   // Full run over beats_q; optionally pokes start+valid during OUT.
   task automatic run(input int gap, input bit poke_out);
      int n;
      n       = beats_q.size();
      start   = 1'b1;
      acc_len = 8'(n);
      tick();
      start   = 1'b0;
      chk("busy_on_start", busy, 1);
      chk("result_cleared_on_start", result_data, 0);
      for (int i = 0; i < n; i++) begin
         brdcast_data_v = 1'b1;
         brdcast_data   = beats_q[i];
         tick();
         brdcast_data_v = 1'b0;
         brdcast_data   = {$urandom, $urandom};
         if (i < n - 1) begin
            chk("no_early_result", result_v, 0);
            repeat (gap) begin
               tick();
               chk("no_result_in_gap", result_v, 0);
            end
         end
      end
      exp_res = model_sum();
      chk("result_v", result_v, 1);
      chk("result_data", result_data, exp_res);
      chk("busy_in_out", busy, 1);
      if (poke_out) begin
         start          = 1'b1;
         acc_len        = 8'd4;
         brdcast_data_v = 1'b1;
      end
      tick();
      start          = 1'b0;
      brdcast_data_v = 1'b0;
      chk("result_v_one_cycle", result_v, 0);
      chk("busy_after_out", busy, 0);
      chk("result_held", result_data, exp_res);
      chk("beat_drop_after_out", beat_drop, RES_W'(poke_out));
   endtask

   initial begin
      // Reset state.
      rst = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_result_v", result_v, 0);
      chk("rst_result_data", result_data, 0);
      chk("rst_beat_drop", beat_drop, 0);
      rst = 1'b1;
      tick();

      // Basic run: weights {4,3,2,1}, beats 2, 3, -1 -> {16,12,8,4}.
      load_w(64'h0004_0003_0002_0001);
      beats_q = {64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003, 64'hffff_ffff_ffff_ffff};
      run(0, 1'b0);
      chk("basic_lane3", result_data[3*ACC_W +: ACC_W], 40'd16);
      chk("basic_lane0", result_data[0 +: ACC_W], 40'd4);

      // Same run with two idle cycles between beats.
      run(2, 1'b0);
      chk("gapped_lane1", result_data[1*ACC_W +: ACC_W], 40'd8);

      // Negative extremes over 255 beats; also start+valid during OUT.
      load_w(64'h8000_8000_8000_8000);
      beats_q.delete();
      repeat (255) beats_q.push_back(64'h8000_8000_8000_8000);
      run(0, 1'b1);
      chk("neg_extreme_lane2", result_data[2*ACC_W +: ACC_W], 40'd273804165120);

      // Dropped and ignored inputs.
      load_w({$urandom, $urandom});
      brdcast_data_v = 1'b1;
      brdcast_data   = {$urandom, $urandom};
      tick();
      brdcast_data_v = 1'b0;
      chk("idle_beat_drop", beat_drop, 1);
      chk("idle_beat_busy", busy, 0);
      tick();
      chk("beat_drop_pulse", beat_drop, 0);

      fill_random(3);
      start          = 1'b1;
      acc_len        = 8'd3;
      brdcast_data_v = 1'b1;
      brdcast_data   = {$urandom, $urandom};
      tick();
      start          = 1'b0;
      brdcast_data_v = 1'b0;
      chk("start_valid_drop", beat_drop, 1);
      chk("start_valid_busy", busy, 1);
      brdcast_data_v = 1'b1;
      brdcast_data   = beats_q[0];
      tick();
      brdcast_data_v = 1'b0;
      chk("accum_no_drop", beat_drop, 0);
      start       = 1'b1;
      acc_len     = 8'd1;
      weight_load = 1'b1;
      weight_data = ~w_model;
      tick();
      start       = 1'b0;
      weight_load = 1'b0;
      chk("accum_start_ignored", result_v, 0);
      for (int i = 1; i < 3; i++) begin
         brdcast_data_v = 1'b1;
         brdcast_data   = beats_q[i];
         tick();
         brdcast_data_v = 1'b0;
      end
      chk("ignored_run_result_v", result_v, 1);
      chk("ignored_run_result", result_data, model_sum());
      exp_res = model_sum();
      tick();
      start   = 1'b1;
      acc_len = 8'd0;
      tick();
      start = 1'b0;
      chk("len0_busy", busy, 0);
      tick();
      chk("len0_busy_later", busy, 0);
      chk("len0_result_held", result_data, exp_res);

      // Reset mid-run after 2 of 5 beats.
      load_w({$urandom, $urandom});
      fill_random(5);
      start   = 1'b1;
      acc_len = 8'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         brdcast_data_v = 1'b1;
         brdcast_data   = beats_q[i];
         tick();
         brdcast_data_v = 1'b0;
      end
      rst = 1'b0;
      tick();
      rst     = 1'b1;
      w_model = '0;
      chk("midrst_busy", busy, 0);
      chk("midrst_result_v", result_v, 0);
      chk("midrst_result_data", result_data, 0);
      chk("midrst_beat_drop", beat_drop, 0);
      repeat (3) begin
         tick();
         chk("midrst_no_result", result_v, 0);
      end
      // Weights were cleared: a run without reload must sum to zero.
      fill_random(1);
      run(0, 1'b0);
      load_w({$urandom, $urandom});
      fill_random(5);
      run(1, 1'b0);

      // Back-to-back: second start in the cycle right after OUT.
      fill_random(4);
      run(0, 1'b0);
      fill_random(6);
      run(0, 1'b0);

      // Randomized runs.
      for (int r = 0; r < 6; r++) begin
         load_w({$urandom, $urandom});
         fill_random(int'($urandom_range(1, 20)));
         run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
